dpb_slot_sched: RTL

Slot scheduler for the 1024×64-bit dual-port frame buffer between the MJPEG byte packer (port A writer) and the 50 MHz UDP/128 reader side. It divides the buffer into a ring of fixed-size slots. It grants one slot at a time to the writer and queues committed slots in order. It presents the oldest committed slot to the reader and reclaims it on release. All of this runs in the camera pixel clock domain; crossing to the reader clock is outside this block.

---
 rtl/dpb_slot_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dpb_slot_sched.sv
// dpb_slot_sched: hands out fixed-size frame-buffer slots to one writer and queues committed slots for one reader.
// Optional statistics outputs are enabled by defining DPB_SLOT_SCHED_STATS_EN.
module dpb_slot_sched #(
    parameter int SLOT_NUM       = 4,
    parameter int SLOT_WORDS     = 256,
    parameter int SLOT_BYTES_MAX = 2048
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_wr_acq,
    output logic        o_wr_grant,
    output logic [2:0]  o_wr_slot,
    output logic [9:0]  o_wr_base_addr,
    input  logic        i_wr_commit,
    input  logic [11:0] i_wr_len,
    input  logic        i_wr_last,
    input  logic        i_wr_abort,
    output logic        o_rd_valid,
    output logic [2:0]  o_rd_slot,
    output logic [9:0]  o_rd_base_addr,
    output logic [11:0] o_rd_len,
    output logic        o_rd_last,
    output logic [14:0] o_rd_frame_rank,
    input  logic        i_rd_release,
    output logic [3:0]  o_count,
    output logic        o_full,
    output logic        o_empty,
`ifdef DPB_SLOT_SCHED_STATS_EN
    output logic [15:0] o_stat_stall_cycles,
    output logic [7:0]  o_stat_abort_cnt,
    output logic [3:0]  o_stat_max_count,
`endif
    output logic        o_error
);

    localparam int PTR_W = $clog2(SLOT_NUM);

    typedef enum logic {
        W_IDLE,
        W_HOLD
    } wstate_e;

    wstate_e          wstate_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_slot_q;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic             full_q;
    logic             empty_q;
    logic             valid_q;
    logic             grant_q;
    logic             error_q;
    logic [14:0]      rank_q;

    logic [11:0]      len_q       [SLOT_NUM];
    logic             last_q      [SLOT_NUM];
    logic [14:0]      slot_rank_q [SLOT_NUM];

    logic in_hold;
    logic len_ok;
    logic grant_ok;
    logic commit_ok;
    logic abort_ok;
    logic release_ok;
    logic proto_err;
    logic hold_d;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here up front) so no latch is inferred.
        in_hold    = (wstate_q == W_HOLD);
        len_ok     = (i_wr_len != '0) && (int'(i_wr_len) <= SLOT_BYTES_MAX);
        grant_ok   = !in_hold && i_wr_acq && !full_q;
        commit_ok  = in_hold && i_wr_commit && !i_wr_abort && len_ok;
        abort_ok   = in_hold && i_wr_abort && !i_wr_commit;
        release_ok = i_rd_release && valid_q;
        proto_err  = ((i_wr_commit || i_wr_abort) && !in_hold)
                   || (in_hold && i_wr_commit && i_wr_abort)
                   || (in_hold && i_wr_commit && !i_wr_abort && !len_ok)
                   || (i_rd_release && !valid_q);
        hold_d     = grant_ok || (in_hold && !commit_ok && !abort_ok);
        count_d    = count_q;
        if (commit_ok && !release_ok) begin
            count_d = count_q + 4'd1;
        end else if (!commit_ok && release_ok) begin
            count_d = count_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            wstate_q  <= W_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_slot_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            valid_q   <= 1'b0;
            grant_q   <= 1'b0;
            error_q   <= 1'b0;
            rank_q    <= '0;
            // NOTE: the slot table is tiny and drives o_rd_* directly, so it is reset to keep outputs at zero.
            for (int i = 0; i < SLOT_NUM; i++) begin
                len_q[i]       <= '0;
                last_q[i]      <= 1'b0;
                slot_rank_q[i] <= '0;
            end
        end else begin
            grant_q <= grant_ok;
            if (grant_ok) begin
                wr_slot_q <= wr_ptr_q;
                wstate_q  <= W_HOLD;
            end
            // The held slot is always wr_ptr; it only advances once the slot is queued.
            if (commit_ok) begin
                len_q[wr_ptr_q]       <= i_wr_len;
                last_q[wr_ptr_q]      <= i_wr_last;
                slot_rank_q[wr_ptr_q] <= rank_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                wstate_q              <= W_IDLE;
                if (i_wr_last) begin
                    rank_q <= rank_q + 15'd1;
                end
            end
            if (abort_ok) begin
                rank_q   <= rank_q + 15'd1;
                wstate_q <= W_IDLE;
            end
            if (release_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (int'(count_d) + int'(hold_d)) == SLOT_NUM;
            empty_q <= (count_d == '0);
            // Drop valid for one cycle after a release so the reader sees an edge per slot.
            valid_q <= (count_d != '0) && !release_ok;
            if (proto_err) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef DPB_SLOT_SCHED_STATS_EN
    logic [15:0] stall_q;
    logic [7:0]  abort_cnt_q;
    logic [3:0]  max_count_q;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            stall_q     <= '0;
            abort_cnt_q <= '0;
            max_count_q <= '0;
        end else begin
            if (i_wr_acq && full_q && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (abort_ok && abort_cnt_q != 8'hFF) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
            if (count_d > max_count_q) begin
                max_count_q <= count_d;
            end
        end
    end

    assign o_stat_stall_cycles = stall_q;
    assign o_stat_abort_cnt    = abort_cnt_q;
    assign o_stat_max_count    = max_count_q;
`endif

    assign o_wr_grant      = grant_q;
    assign o_wr_slot       = 3'(wr_slot_q);
    assign o_wr_base_addr  = 10'(int'(wr_slot_q) * SLOT_WORDS);
    assign o_rd_valid      = valid_q;
    assign o_rd_slot       = 3'(rd_ptr_q);
    assign o_rd_base_addr  = 10'(int'(rd_ptr_q) * SLOT_WORDS);
    assign o_rd_len        = len_q[rd_ptr_q];
    assign o_rd_last       = last_q[rd_ptr_q];
    assign o_rd_frame_rank = slot_rank_q[rd_ptr_q];
    assign o_count         = count_q;
    assign o_full          = full_q;
    assign o_empty         = empty_q;
    assign o_error         = error_q;

endmodule
